// File: rtl/nave_if.sv
// Button, scan-position and ship/shot state bundle between the
// input/raster side and the ship controller.
interface nave_if;
    logic [9:0]  h_counter;
    logic [9:0]  v_counter;
    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    logic        shot_hit;
    logic [10:0] mem_X_barra;
    logic [10:0] shot_x;
    logic [9:0]  shot_y;
    logic        shot_active;
    logic        frame_tick;

    modport master (
        output h_counter, v_counter,
        output btn_left, btn_right, btn_fire, shot_hit,
        input  mem_X_barra, shot_x, shot_y,
        input  shot_active, frame_tick
    );

    modport slave (
        input  h_counter, v_counter,
        input  btn_left, btn_right, btn_fire, shot_hit,
        output mem_X_barra, shot_x, shot_y,
        output shot_active, frame_tick
    );
endinterface

// File: rtl/nave_ctrl.sv
// Player ship controller: per-frame horizontal motion plus a
// single-shot launch/flight/cooldown state machine.
module nave_ctrl #(
    parameter int SCREEN_W        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SHIP_W          = 11,
    parameter int SHIP_Y          = 150,
    parameter int START_X         = 314,
    parameter int STEP            = 2,
    parameter int SHOT_H          = 4,
    parameter int SHOT_STEP       = 4,
    parameter int COOLDOWN_FRAMES = 8
) (
    input logic   clk,
    input logic   reset,
    nave_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FLYING, S_COOLDOWN} state_t;

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [11:0]   X_MAX    = 12'(SCREEN_W - SHIP_W);
    localparam logic [10:0]   X_START  = 11'(START_X);
    localparam logic [10:0]   X_STEP   = 11'(STEP);
    localparam logic [10:0]   X_CENTER = 11'(SHIP_W / 2);
    localparam logic [9:0]    Y_LAUNCH = 10'(SHIP_Y - SHOT_H);
    localparam logic [9:0]    Y_STEP   = 10'(SHOT_STEP);
    localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES);
    localparam logic [CW-1:0] CD_ONE   = CW'(1);

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   sx_q, sx_d;
    logic [9:0]    sy_q, sy_d;
    logic          act_q, act_d;
    logic          pend_q, pend_d;
    logic          fire_prev_q, fire_prev_d;
    logic [CW-1:0] cd_q, cd_d;
    logic          ftick_q, ftick_d;

    logic          tick;
    logic          fire_edge;
    logic [11:0]   x_up;

    always_comb begin
        tick = (bus.v_counter == 10'(V_ACTIVE)) &&
               (bus.h_counter == 10'd0);
        fire_edge = bus.btn_fire && !fire_prev_q;
        x_up = {1'b0, x_q} + {1'b0, X_STEP};

        state_d     = state_q;
        x_d         = x_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        act_d       = act_q;
        pend_d      = pend_q;
        cd_d        = cd_q;
        fire_prev_d = bus.btn_fire;
        ftick_d     = tick;

        // Opposing buttons cancel; motion uses the pre-tick position.
        if (tick && (bus.btn_left ^ bus.btn_right)) begin
            if (bus.btn_left)
                x_d = (x_q < X_STEP) ? 11'd0 : x_q - X_STEP;
            else
                x_d = (x_up > X_MAX) ? X_MAX[10:0] : x_up[10:0];
        end

        unique case (state_q)
            S_IDLE: begin
                if (tick && pend_q) begin
                    sx_d    = x_q + X_CENTER;
                    sy_d    = Y_LAUNCH;
                    act_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_FLYING;
                end else if (fire_edge) begin
                    pend_d = 1'b1;
                end
            end
            S_FLYING: begin
                if (bus.shot_hit || (tick && (sy_q < Y_STEP))) begin
                    act_d   = 1'b0;
                    cd_d    = CD_LOAD;
                    state_d = S_COOLDOWN;
                end else if (tick) begin
                    sy_d = sy_q - Y_STEP;
                end
            end
            S_COOLDOWN: begin
                if (tick) begin
                    cd_d = cd_q - CD_ONE;
                    if (cd_q <= CD_ONE)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= X_START;
            sx_q        <= '0;
            sy_q        <= '0;
            act_q       <= 1'b0;
            pend_q      <= 1'b0;
            fire_prev_q <= 1'b0;
            cd_q        <= '0;
            ftick_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            fire_prev_q <= fire_prev_d;
            cd_q        <= cd_d;
            ftick_q     <= ftick_d;
        end
    end

    assign bus.mem_X_barra = x_q;
    assign bus.shot_x      = sx_q;
    assign bus.shot_y      = sy_q;
    assign bus.shot_active = act_q;
    assign bus.frame_tick  = ftick_q;
endmodule
